timer16: RTL and testbench
==========================

# timer16

Memory-mapped 16-bit down-counting timer on the d16 system bus, decoded by syscon as an additional slave. It feeds the CPU's `i_int` input, which is currently unconnected. Software loads a reload value, selects one-shot or periodic mode and a clock prescaler. The block raises a level interrupt on each underflow until software acknowledges it.

## Interface
- `RELOAD_INIT`, default 16'h0000: reset value of RELOAD and COUNT.
- `i_clk`  in  1: system clock; all state changes on its rising edge.
- `i_reset`  in  1: reset, asynchronous and active-high.
- `i_dat`  in  16: bus write data.
- `o_dat`  out  16: bus read data.
- `i_addr`  in  2: register select (bus addr[1:0]).
- `i_we`  in  1: write enable, qualified by `i_cyc`.
- `i_cyc`  in  1: slave select from syscon.
- `o_int`  out  1: interrupt to CPU `i_int`, level, active-high.

## Operation
- Register map, selected by `i_addr`:
  - 0 COUNT (r/w): current count.
  - 1 RELOAD (r/w).
  - 2 CTRL (r/w):
    - bit0 EN
    - bit1 AUTO (1 = periodic, 0 = one-shot)
    - bit2 IE
    - bits[15:8] PSC
    - other bits read 0.
  - 3 STATUS: bit0 IF; write 1 clears, write 0 has no effect; other bits read 0.
- Write: takes effect at the rising edge where `i_cyc && i_we`.
- Read: `o_dat` is combinational from the selected register while `i_cyc && !i_we`; otherwise 16'h0000.
- Prescaler:
  - 8-bit `psc_cnt` counts cycles while EN=1.
  - `tick` is asserted in the cycle where `psc_cnt == PSC`, and `psc_cnt` returns to 0 at that edge; otherwise `psc_cnt` increments.
  - While EN=0, `psc_cnt` is held at 0.
  - Any CTRL write clears `psc_cnt`.
- On `tick`:
  - COUNT != 0: COUNT decrements by 1.
  - COUNT == 0: IF is set. If AUTO=1, COUNT loads RELOAD. If AUTO=0, EN clears and COUNT stays 0.
- `o_int` = IF & IE (combinational from registers).
- Arithmetic is 16-bit unsigned; COUNT never wraps below 0, because underflow is handled by reload/stop.
- Simultaneous events:
  - A bus write to COUNT on a tick edge wins; the decrement/reload is discarded.
  - A write to CTRL on a tick edge: the CTRL write wins (including EN), and the tick's COUNT update still applies.
  - IF set and a STATUS clear on the same edge: set wins, IF stays 1.
- Reset mid-count: all state returns to reset values immediately; no pending interrupt survives.

## Timing
- Reset values:
  - COUNT = RELOAD = RELOAD_INIT
  - CTRL = 0, IF = 0, `psc_cnt` = 0
  - `o_int` = 0, `o_dat` = 0
- Bus: zero wait states; read data is valid in the same cycle as `i_cyc`. Written values are visible on reads from the next cycle.
- Tick period: PSC+1 cycles. The first tick after a CTRL write setting EN occurs PSC+1 cycles after that edge.
- Periodic mode: IF sets every (RELOAD+1)*(PSC+1) cycles.
- One-shot from COUNT=N: IF sets (N+1)*(PSC+1) cycles after enable.
- `o_int` rises in the cycle following the underflow edge, with no extra latency beyond the IF flop.

## Configuration
- `TIMER16_PRESCALER_EN`:
  - Defined: the prescaler operates as described.
  - Undefined: `psc_cnt` is not built, `tick` = EN every cycle, CTRL[15:8] ignores writes and reads 0.

## Test plan
- Reset: assert `i_reset` mid-count with IF=1, IE=1 → `o_int`=0, COUNT reads RELOAD_INIT, and CTRL and STATUS read 0 immediately.
- Periodic mode:
  - Stimulus: RELOAD=3, COUNT=3, CTRL=0x0007 (PSC=0, AUTO, IE, EN).
  - Required: IF sets every 4 cycles; COUNT sequence 3,2,1,0,3; `o_int` rises one cycle after COUNT=0 is ticked.
- One-shot with prescaler:
  - Stimulus: COUNT=2, CTRL=0x0305 (PSC=3, IE, EN).
  - Required: IF sets 12 cycles after the write, EN reads 0 afterwards, COUNT stays 0 with no further IF.
- Acknowledge: write STATUS=0x0001 → `o_int` drops next cycle. Clear coinciding with an underflow edge → IF remains 1.
- Write priority: write COUNT=0x0100 on a tick edge → COUNT reads 0x0100, not 0x00FF.
- Macro off (`TIMER16_PRESCALER_EN` undefined): write CTRL=0xFF05 → CTRL reads 0x0005, COUNT decrements every cycle.

Source files
------------

// File: rtl/timer16.sv
// timer16 -- memory-mapped 16-bit down-counting timer, d16 bus slave.
//
// Registers (i_addr):
//   0 COUNT  r/w  current count
//   1 RELOAD r/w  value loaded on underflow in periodic mode
//   2 CTRL   r/w  bit0 EN, bit1 AUTO (1 periodic / 0 one-shot), bit2 IE,
//                 bits[15:8] PSC; other bits read 0
//   3 STATUS      bit0 IF; write 1 clears, write 0 ignored
//
// Ports:
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-high reset
//   i_dat    bus write data
//   o_dat    bus read data, combinational while i_cyc && !i_we, else 0
//   i_addr   register select
//   i_we     write enable, qualified by i_cyc
//   i_cyc    slave select
//   o_int    level interrupt = IF & IE
//
// Build option: TIMER16_PRESCALER_EN
//   defined   -> 8-bit prescaler, one tick every PSC+1 cycles
//   undefined -> no prescaler, tick every cycle while EN, PSC reads 0
module timer16 #(
  parameter logic [15:0] RELOAD_INIT = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_dat,
  output logic [15:0] o_dat,
  input  logic [1:0]  i_addr,
  input  logic        i_we,
  input  logic        i_cyc,
  output logic        o_int
);

  logic [15:0] count;
  logic [15:0] reload;
  logic        en;
  logic        auto_rl;
  logic        ie;
  logic        irq_flag;
  logic [7:0]  psc;

  logic        wr;
  logic        wr_count;
  logic        wr_reload;
  logic        wr_ctrl;
  logic        wr_status;
  logic        tick;
  logic        underflow;

  assign wr        = i_cyc && i_we;
  assign wr_count  = wr && (i_addr == 2'd0);
  assign wr_reload = wr && (i_addr == 2'd1);
  assign wr_ctrl   = wr && (i_addr == 2'd2);
  assign wr_status = wr && (i_addr == 2'd3);

  assign underflow = tick && (count == 16'h0000);

`ifdef TIMER16_PRESCALER_EN
  logic [7:0] psc_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      psc <= '0;
    end else if (wr_ctrl) begin
      psc <= i_dat[15:8];
    end
  end

  // A CTRL write restarts the prescaler so the first tick after enabling
  // lands exactly PSC+1 cycles after the write edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      psc_cnt <= '0;
    end else if (wr_ctrl || !en || tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 8'd1;
    end
  end

  assign tick = en && (psc_cnt == psc);
`else
  assign psc  = '0;
  assign tick = en;
`endif

  // Bus write wins over the tick update; underflow with a concurrent write
  // still raises IF (handled in the flag logic below).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= RELOAD_INIT;
    end else if (wr_count) begin
      count <= i_dat;
    end else if (tick) begin
      if (count != 16'h0000) begin
        count <= count - 16'd1;
      end else if (auto_rl) begin
        count <= reload;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      reload <= RELOAD_INIT;
    end else if (wr_reload) begin
      reload <= i_dat;
    end
  end

  // A CTRL write on the underflow edge overrides the one-shot EN clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
    end else if (wr_ctrl) begin
      en      <= i_dat[0];
      auto_rl <= i_dat[1];
      ie      <= i_dat[2];
    end else if (underflow && !auto_rl) begin
      en      <= 1'b0;
    end
  end

  // Setting has priority over a software clear on the same edge so that
  // an underflow is never lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      irq_flag <= 1'b0;
    end else if (underflow) begin
      irq_flag <= 1'b1;
    end else if (wr_status && i_dat[0]) begin
      irq_flag <= 1'b0;
    end
  end

  always_comb begin
    o_dat = '0;
    if (i_cyc && !i_we) begin
      case (i_addr)
        2'd0:    o_dat = count;
        2'd1:    o_dat = reload;
        2'd2:    o_dat = {psc, 5'b00000, ie, auto_rl, en};
        default: o_dat = {15'h0000, irq_flag};
      endcase
    end
  end

  assign o_int = irq_flag && ie;

endmodule

// File: tb/tb_timer16.sv
module tb_timer16;

  logic        i_clk;
  logic        i_reset;
  logic [15:0] i_dat;
  logic [15:0] o_dat;
  logic [1:0]  i_addr;
  logic        i_we;
  logic        i_cyc;
  logic        o_int;

  timer16 #(.RELOAD_INIT(16'h0000)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_dat  (i_dat),
    .o_dat  (o_dat),
    .i_addr (i_addr),
    .i_we   (i_we),
    .i_cyc  (i_cyc),
    .o_int  (o_int)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [15:0] dat;
    logic        irq;
  } exp_t;

  exp_t q[$];
  int   vectors;
  int   miscompares;

  // Reference model: architectural register state plus a cycle index.
  // Ticks are derived arithmetically from the cycle index relative to the
  // most recent CTRL write rather than from a prescaler counter.
  int unsigned m_count, m_reload, m_psc;
  bit          m_en, m_auto, m_ie, m_if;
  longint      cyc_no, m_anchor;

  function automatic int unsigned model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_count;
      2'd1:    return m_reload;
      2'd2:    return (m_psc << 8) | (int'(m_ie) << 2) | (int'(m_auto) << 1) | int'(m_en);
      default: return int'(m_if);
    endcase
  endfunction

  task automatic model_reset();
    m_count  = 0;
    m_reload = 0;
    m_psc    = 0;
    m_en     = 0;
    m_auto   = 0;
    m_ie     = 0;
    m_if     = 0;
    m_anchor = cyc_no;
  endtask

  task automatic model_step(input logic c, input logic w, input logic [1:0] a,
                            input logic [15:0] d);
    bit          tick, under, wr;
    int unsigned nc;
    tick  = m_en && (((cyc_no - m_anchor) % (longint'(m_psc) + 1)) == longint'(m_psc));
    under = tick && (m_count == 0);
    wr    = c && w;
    nc    = m_count;
    if (wr && a == 2'd0) nc = d;
    else if (tick) nc = (m_count == 0) ? (m_auto ? m_reload : 0) : m_count - 1;
    if (wr && a == 2'd1) m_reload = d;
    if (wr && a == 2'd2) begin
      m_en   = d[0];
      m_auto = d[1];
      m_ie   = d[2];
`ifdef TIMER16_PRESCALER_EN
      m_psc  = d[15:8];
`else
      m_psc  = 0;
`endif
      m_anchor = cyc_no + 1;
    end else if (under && !m_auto) begin
      m_en = 0;
    end
    if (under) m_if = 1;
    else if (wr && a == 2'd3 && d[0]) m_if = 0;
    m_count = nc;
  endtask

  // One bus cycle: drive inputs just after the edge, queue the expected
  // outputs for this cycle, then advance the model across the next edge.
  task automatic bus(input logic rst, input logic c, input logic w,
                     input logic [1:0] a, input logic [15:0] d);
    exp_t e;
    @(posedge i_clk);
    #1;
    i_reset = rst;
    i_cyc   = c;
    i_we    = w;
    i_addr  = a;
    i_dat   = d;
    if (rst) model_reset();
    e.dat = (c && !w) ? 16'(model_read(a)) : 16'h0000;
    e.irq = m_if && m_ie;
    q.push_back(e);
    if (!rst) model_step(c, w, a, d);
    cyc_no++;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
    bus(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    bus(1'b0, 1'b1, 1'b0, a, 16'h0000);
  endtask

  always @(negedge i_clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (o_dat !== e.dat) begin
        miscompares++;
        $display("FAIL o_dat t=%0t addr=%0d got=%h exp=%h", $time, i_addr, o_dat, e.dat);
      end
      if (o_int !== e.irq) begin
        miscompares++;
        $display("FAIL o_int t=%0t got=%b exp=%b", $time, o_int, e.irq);
      end
    end
  end

  initial begin
    logic [7:0]  p;
    logic [15:0] d;
    logic [1:0]  a;
    int unsigned r;
    vectors     = 0;
    miscompares = 0;
    cyc_no      = 0;
    i_reset = 1'b1;
    i_cyc   = 1'b0;
    i_we    = 1'b0;
    i_addr  = 2'd0;
    i_dat   = 16'h0000;
    model_reset();

    // reset state of every register
    for (int i = 0; i < 4; i++) bus(1'b1, 1'b1, 1'b0, 2'(i), 16'h0000);

    // periodic, PSC=0
    wr_reg(2'd1, 16'd3);
    wr_reg(2'd0, 16'd3);
    wr_reg(2'd2, 16'h0007);
    for (int i = 0; i < 10; i++) rd_reg(2'd0);
    rd_reg(2'd3);

    // acknowledge, then repeated clears so one lands on an underflow edge
    wr_reg(2'd3, 16'h0001);
    rd_reg(2'd3);
    for (int i = 0; i < 8; i++) wr_reg(2'd3, 16'h0001);
    rd_reg(2'd3);

    // write priority on a tick edge
    wr_reg(2'd0, 16'h0100);
    rd_reg(2'd0);

    // one-shot with prescaler
    wr_reg(2'd2, 16'h0000);
    wr_reg(2'd3, 16'h0001);
    wr_reg(2'd0, 16'd2);
    wr_reg(2'd2, 16'h0305);
    for (int i = 0; i < 16; i++) rd_reg(2'(i % 4));
    for (int i = 0; i < 6; i++) rd_reg(2'd0);

    // high CTRL bits, counting every cycle when prescaler is absent
    wr_reg(2'd2, 16'hFF05);
    rd_reg(2'd2);
    for (int i = 0; i < 4; i++) rd_reg(2'd0);

    // reset mid-count with interrupt pending
    wr_reg(2'd1, 16'd5);
    wr_reg(2'd0, 16'd0);
    wr_reg(2'd2, 16'h0007);
    rd_reg(2'd3);
    rd_reg(2'd3);
    bus(1'b1, 1'b1, 1'b0, 2'd2, 16'h0000);
    rd_reg(2'd0);
    rd_reg(2'd3);
    rd_reg(2'd2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      if (r < 2) begin
        bus(1'b1, 1'b1, 1'b0, a, 16'h0000);
      end else if (r < 50) begin
        rd_reg(a);
      end else if (r < 70) begin
        bus(1'b0, 1'b0, 1'($urandom_range(0, 1)), a, 16'($urandom));
      end else begin
        case (a)
          2'd0, 2'd1: d = 16'($urandom_range(0, 6));
          2'd2: begin
            p = 8'($urandom_range(0, 3));
            d = {p, 8'($urandom)};
          end
          default: d = 16'($urandom);
        endcase
        wr_reg(a, d);
      end
    end

    bus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      @(negedge i_clk);
      #1;
    end
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    if (vectors == 0) begin
      miscompares++;
      $display("FAIL vectors got=0 required>0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
